// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-sample debounce, press/release strobes.
// Optional auto-repeat of press_stb_o while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 5000,
  parameter int unsigned REPEAT_CYCLES   = 1000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_i,
  output logic pressed_o,
  output logic press_stb_o,
  output logic release_stb_o
);

  // state    | meaning
  // RELEASED | debounced level low, waiting for an accepted press
  // PRESSED  | debounced level high, hold timer running (auto-repeat build)
  // REPEAT   | debounced level high, emitting periodic press strobes (auto-repeat build)

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES == 0 || HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_param_check
    $error("button_debounce: cycle parameters must all be at least 1");
  end

`ifdef BUTTON_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2
  } state_t;

  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
`else
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1
  } state_t;
`endif

  state_t           state;
  logic             sync_meta;
  logic             btn_s;
  logic [CNT_W-1:0] stable_cnt;
  logic             differ;
  logic             accept;

  // The first stage may go metastable; only btn_s is consumed downstream.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      sync_meta <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      sync_meta <= button_i;
      btn_s     <= sync_meta;
    end
  end

  assign differ = (btn_s != pressed_o);
  assign accept = differ && (stable_cnt == CNT_LAST);

  // Any sample matching the current level restarts the count.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      stable_cnt <= '0;
    end else if (!differ || accept) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state         <= RELEASED;
      pressed_o     <= 1'b0;
      press_stb_o   <= 1'b0;
      release_stb_o <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      hold_cnt      <= '0;
`endif
    end else begin
      press_stb_o   <= 1'b0;
      release_stb_o <= 1'b0;
      case (state)
        RELEASED: begin
          if (accept) begin
            state       <= PRESSED;
            pressed_o   <= 1'b1;
            press_stb_o <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        PRESSED: begin
          if (accept) begin
            state         <= RELEASED;
            pressed_o     <= 1'b0;
            release_stb_o <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= REPEAT;
            press_stb_o <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
`ifdef BUTTON_AUTOREPEAT_EN
        // A release accepted on the same edge as a repeat tick suppresses the repeat.
        REPEAT: begin
          if (accept) begin
            state         <= RELEASED;
            pressed_o     <= 1'b0;
            release_stb_o <= 1'b1;
          end else if (hold_cnt == REPEAT_LAST) begin
            press_stb_o <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state     <= RELEASED;
          pressed_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5.
module tb_button_debounce;

  localparam int D    = 4;
  localparam int H    = 10;
  localparam int R    = 5;
  localparam int NONE = 100000;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clock_i = 1'b0;
  logic reset_i;
  logic button_i;
  logic pressed_o;
  logic press_stb_o;
  logic release_stb_o;

  int tests = 0;
  int fails = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .button_i(button_i),
    .pressed_o(pressed_o),
    .press_stb_o(press_stb_o),
    .release_stb_o(release_stb_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input int e, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: got %b expected %b", tag, e, obs, exp);
    end
  endtask

  // Press accepted at edge p, release at edge r (NONE = never); repeats fall between.
  function automatic logic exp_press(input int e, input int p, input int r);
    if (e == p) return 1'b1;
    if (AR && e >= p + H && e < r && ((e - p - H) % R) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input string tag, input int e, input int p, input int r);
    tick();
    check({tag, ".pressed"}, e, pressed_o, (e >= p && e < r));
    check({tag, ".press_stb"}, e, press_stb_o, exp_press(e, p, r));
    check({tag, ".release_stb"}, e, release_stb_o, (e == r));
  endtask

  initial begin
    reset_i  = 1'b0;
    button_i = 1'b0;

    // 1: reset held three cycles, then idle
    for (int c = 0; c < 3; c++) step("rst", c + 1, NONE, NONE);
    reset_i = 1'b1;
    for (int c = 0; c < 4; c++) step("idle", c + 1, NONE, NONE);

    // 2: clean press held 20 cycles, then clean release
    for (int c = 0; c < 30; c++) begin
      button_i = (c < 20);
      step("clean", c + 1, 6, 26);
    end

    // 3: toggle every 2 cycles for 12 cycles, then hold; release afterwards
    for (int c = 0; c < 36; c++) begin
      button_i = (c < 12) ? (((c / 2) % 2) == 0) : (c < 26);
      step("bounce", c + 1, 18, 32);
    end

    // 4: 3-cycle glitch is rejected
    for (int c = 0; c < 12; c++) begin
      button_i = (c < 3);
      step("glitch", c + 1, NONE, NONE);
    end

    // 5: reset after two stable samples with the button held
    button_i = 1'b1;
    for (int c = 0; c < 4; c++) step("precnt", c + 1, NONE, NONE);
    reset_i = 1'b0;
    for (int c = 0; c < 2; c++) step("midrst", c + 1, NONE, NONE);
    reset_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      button_i = (c < 14);
      step("postrst", c + 1, 6, 20);
    end

    // 6: long hold; release lands on the edge a repeat would fire
    for (int c = 0; c < 50; c++) begin
      button_i = (c < 35);
      step("hold", c + 1, 6, 41);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
